// File: rtl/uart_pkg.sv
// Shared UART definitions: character width default and FIFO pointer sizing.
package uart_pkg;

    localparam int DLEN_DEFAULT = 8;

    // Pointer carries one extra wrap bit above the index bits.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_tout_timer.sv
// Saturating idle counter; flags a timeout once TOUT uncleared enabled cycles elapse.
module uart_rx_tout_timer #(
    parameter int TOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int TW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TOUT);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_next;
    logic          r_timeout;

    always_comb begin
        w_next = r_timer;
        if (i_clear) begin
            w_next = '0;
        end else if (i_enable && (r_timer != TMAX)) begin
            w_next = r_timer + TW'(1);
        end
    end

    // Timeout is registered from the next count so it rises on the edge the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timer   <= w_next;
            r_timeout <= (TOUT != 0) && i_enable && !i_clear && (w_next == TMAX);
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular first-word fall-through FIFO with overflow and idle-timeout reporting.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DLEN  = DLEN_DEFAULT,
    parameter  int DEPTH = 16,
    parameter  int TOUT  = 1000,
    localparam int CW    = ptrWidth(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wvalid,
    input  logic [DLEN-1:0] i_wdata,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DLEN-1:0] o_rdata,
    output logic [CW-1:0]   o_count,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_overflow,
    input  logic            i_ovf_clr,
    output logic            o_timeout
);

    localparam int IW = CW - 1;

    logic [DLEN-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rdAcc;
    logic w_wrAcc;
    logic w_drop;

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[IW-1:0] == r_rdPtr[IW-1:0]) && (r_wrPtr[IW] != r_rdPtr[IW]);
    assign w_rdAcc = !w_empty && i_rready;
    // A full FIFO still takes a write when the head is leaving in the same cycle.
    assign w_wrAcc = i_wvalid && (!w_full || w_rdAcc);
    assign w_drop  = i_wvalid && !w_wrAcc;

    always_ff @(posedge clk) begin
        if (w_wrAcc) begin
            r_mem[r_wrPtr[IW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + CW'(1);
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + CW'(1);
            end
            case ({w_wrAcc, w_rdAcc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear wins so no loss goes unreported.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_rx_tout_timer #(
        .TOUT(TOUT)
    ) u_toutTimer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wrAcc || w_rdAcc || w_drop || w_empty),
        .i_enable (!w_empty),
        .o_timeout(o_timeout)
    );

    assign o_rvalid   = !w_empty;
    assign o_rdata    = r_mem[r_rdPtr[IW-1:0]];
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the driver queues expected characters, a monitor checks each read handshake.
module tb_uart_rx_fifo;

    localparam int DLEN  = 8;
    localparam int DEPTH = 4;
    localparam int TOUT  = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            i_wvalid;
    logic [DLEN-1:0] i_wdata;
    logic            o_rvalid;
    logic            i_rready;
    logic [DLEN-1:0] o_rdata;
    logic [CW-1:0]   o_count;
    logic            o_empty;
    logic            o_full;
    logic            o_overflow;
    logic            i_ovf_clr;
    logic            o_timeout;

    int testsRun    = 0;
    int testsFailed = 0;
    int modelCount  = 0;
    logic [DLEN-1:0] expQ [$];

    uart_rx_fifo #(
        .DLEN (DLEN),
        .DEPTH(DEPTH),
        .TOUT (TOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wvalid  (i_wvalid),
        .i_wdata   (i_wdata),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready),
        .o_rdata   (o_rdata),
        .o_count   (o_count),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_overflow(o_overflow),
        .i_ovf_clr (i_ovf_clr),
        .o_timeout (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, records any character the FIFO will accept, then returns just after the edge.
    task automatic applyStimulus(input logic wv, input logic [DLEN-1:0] wd, input logic rr, input logic clr);
        logic rdAcc;
        logic wrAcc;
        i_wvalid  = wv;
        i_wdata   = wd;
        i_rready  = rr;
        i_ovf_clr = clr;
        rdAcc = (modelCount > 0) && rr;
        wrAcc = wv && ((modelCount < DEPTH) || rdAcc);
        if (wrAcc) expQ.push_back(wd);
        modelCount = modelCount + int'(wrAcc) - int'(rdAcc);
        @(posedge clk);
        #1;
        i_wvalid  = 1'b0;
        i_wdata   = '0;
        i_rready  = 1'b0;
        i_ovf_clr = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        modelCount = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (modelCount > 0 && budget < 200) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            budget++;
        end
        checkOutput("drain_complete", o_empty, 1'b1);
    endtask

    // Monitor: inputs are stable between edges, so a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && o_rvalid && i_rready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_read", 32'h1, 32'h0);
            end else begin
                checkOutput("rdata", o_rdata, expQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int cyc;
        logic rr;
        logic wv;
        logic [7:0] ch;

        rst       = 1'b1;
        i_wvalid  = 1'b0;
        i_wdata   = '0;
        i_rready  = 1'b0;
        i_ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        applyReset();

        checkOutput("reset_count", o_count, 0);
        checkOutput("reset_empty", o_empty, 1);
        checkOutput("reset_full", o_full, 0);
        checkOutput("reset_rvalid", o_rvalid, 0);
        checkOutput("reset_overflow", o_overflow, 0);
        checkOutput("reset_timeout", o_timeout, 0);

        // Single character in and out.
        idle(8);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("single_rvalid", o_rvalid, 1);
        checkOutput("single_rdata", o_rdata, 8'hA5);
        checkOutput("single_count", o_count, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("single_empty", o_empty, 1);
        checkOutput("single_count_after", o_count, 0);

        // Fill, drop one, drain, clear overflow.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("fill_full", o_full, 1);
        checkOutput("fill_overflow_pre", o_overflow, 0);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("drop_full", o_full, 1);
        checkOutput("drop_count", o_count, 4);
        checkOutput("drop_overflow", o_overflow, 1);
        drain();
        checkOutput("drained_overflow_sticky", o_overflow, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_clr", o_overflow, 0);

        // Full with simultaneous write and read.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("fullrw_count", o_count, 4);
        checkOutput("fullrw_full", o_full, 1);
        checkOutput("fullrw_overflow", o_overflow, 0);
        drain();

        // Streaming with random consumer readiness across several pointer wraps.
        sent = 0;
        cyc  = 0;
        while (sent < 48 && cyc < 1000) begin
            rr = 1'($urandom_range(0, 1));
            wv = (modelCount < DEPTH) || rr;
            ch = 8'(sent);
            applyStimulus(wv, ch, rr, 1'b0);
            if (wv) sent++;
            checkOutput("stream_count", o_count, modelCount);
            checkOutput("stream_full", o_full, (modelCount == DEPTH));
            cyc++;
        end
        checkOutput("stream_sent", sent, 48);
        drain();
        checkOutput("stream_overflow", o_overflow, 0);

        // Idle timeout.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        idle(TOUT - 1);
        checkOutput("timeout_early", o_timeout, 0);
        idle(1);
        checkOutput("timeout_set", o_timeout, 1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        checkOutput("timeout_clr_write", o_timeout, 0);
        drain();
        idle(TOUT + 5);
        checkOutput("timeout_empty", o_timeout, 0);

        // Reset mid-operation with three entries, overflow and timeout set.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h35, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("pre_rst_count", o_count, 3);
        checkOutput("pre_rst_overflow", o_overflow, 1);
        idle(TOUT);
        checkOutput("pre_rst_timeout", o_timeout, 1);
        applyReset();
        checkOutput("midrst_count", o_count, 0);
        checkOutput("midrst_rvalid", o_rvalid, 0);
        checkOutput("midrst_overflow", o_overflow, 0);
        checkOutput("midrst_timeout", o_timeout, 0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("post_rst_rdata", o_rdata, 8'h3C);
        drain();

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
